// File: rtl/instr_fetch_unit_if.sv
// Instruction fetch bus: memory read port, redirect input and
// the valid/ready instruction handoff to the decoder.
interface instr_fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, registers one fetched word,
// handles redirect/flush and halts on a bad PC.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int unsigned MEM_WORDS = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    instr_fetch_unit_if.master        bus,
    output logic                      halted,
    output logic                      fault,
    output logic [31:0]               fetch_count
);
    localparam logic [31:0] WORDS = 32'(MEM_WORDS);

    typedef enum logic {RUN, HALT} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [31:0] cnt_q, cnt_d;

    logic pc_ok, redir_ok, accept, load;

    function automatic logic addr_ok(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> 2) < WORDS);
    endfunction

    assign pc_ok    = addr_ok(pc_q);
    assign redir_ok = addr_ok(bus.redirect_pc);
    assign accept   = valid_q & bus.instr_ready;
    assign load     = (state_q == RUN) & pc_ok & (~valid_q | bus.instr_ready)
                    & ~bus.redirect_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    // Redirect beats everything; a bad PC in RUN parks the unit.
    always_comb begin
        state_d = state_q;
        if (bus.redirect_valid) begin
            state_d = redir_ok ? RUN : HALT;
        end else if (state_q == RUN && !pc_ok) begin
            state_d = HALT;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        if (accept && cnt_q != 32'hFFFF_FFFF) begin
            cnt_d = cnt_q + 32'd1;
        end
        if (bus.redirect_valid) begin
            pc_d    = bus.redirect_pc;
            valid_d = 1'b0;
            fault_d = ~redir_ok;
        end else if (load) begin
            instr_d = bus.imem_data;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
        end else begin
            if (accept) begin
                valid_d = 1'b0;
            end
            if (state_q == RUN && !pc_ok) begin
                fault_d = 1'b1;
            end
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = ipc_q;
    assign halted          = (state_q == HALT);
    assign fault           = fault_q;
    assign fetch_count     = cnt_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table followed by
// randomized traffic against a transaction-level reference model.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        halted;
    logic        fault;
    logic [31:0] fetch_count;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.master),
        .halted      (halted),
        .fault       (fault),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [32];

    assign bus.imem_data = (bus.imem_addr < 32'd128) ? mem[bus.imem_addr[6:2]]
                                                     : (32'hBAD0_0000 ^ bus.imem_addr);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_ipc;
        logic [31:0] e_instr;
        logic [31:0] e_addr;
        logic        e_halt;
        logic        e_fault;
        logic [31:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rpc,
                                input logic rdy, input logic ev, input logic [31:0] eipc,
                                input logic [31:0] ein, input logic [31:0] ea,
                                input logic eh, input logic ef, input logic [31:0] ec);
        vec_t v;
        v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.e_valid = ev; v.e_ipc = eipc; v.e_instr = ein; v.e_addr = ea;
        v.e_halt = eh; v.e_fault = ef; v.e_cnt = ec;
        return v;
    endfunction

    // Reference model: stream-level view of the fetch unit
    logic [31:0] m_pc, m_instr, m_ipc, m_cnt;
    logic        m_valid, m_halt, m_fault;

    function automatic logic good(input logic [31:0] a);
        return (a % 4 == 0) && (a / 4 < 32);
    endfunction

    task automatic model_step(input logic r, input logic rv, input logic [31:0] rpc,
                              input logic rdy);
        logic taken;
        if (r) begin
            m_pc = 0; m_instr = 0; m_ipc = 0; m_cnt = 0;
            m_valid = 0; m_halt = 0; m_fault = 0;
            return;
        end
        taken = m_valid && rdy;
        if (taken && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (rv) begin
            m_pc = rpc;
            m_valid = 0;
            m_halt = !good(rpc);
            m_fault = m_halt;
        end else if (!m_halt && !good(m_pc)) begin
            m_halt = 1;
            m_fault = 1;
            if (taken) m_valid = 0;
        end else if (!m_halt && (!m_valid || rdy)) begin
            m_instr = mem[m_pc / 4];
            m_ipc = m_pc;
            m_valid = 1;
            m_pc = m_pc + 4;
        end else if (taken) begin
            m_valid = 0;
        end
    endtask

    task automatic drive(input logic r, input logic rv, input logic [31:0] rpc,
                         input logic rdy);
        rst = r;
        bus.redirect_valid = rv;
        bus.redirect_pc = rpc;
        bus.instr_ready = rdy;
    endtask

    vec_t tbl[$];

    initial begin
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 32; k++) mem[k] = 32'h100 + 32'(k);

        tbl.push_back(mk(1,0,32'h00,1, 0,32'h00,32'h000,32'h00,0,0,0));
        tbl.push_back(mk(0,0,32'h00,1, 1,32'h00,32'h100,32'h04,0,0,0));
        tbl.push_back(mk(0,0,32'h00,1, 1,32'h04,32'h101,32'h08,0,0,1));
        tbl.push_back(mk(0,0,32'h00,1, 1,32'h08,32'h102,32'h0C,0,0,2));
        tbl.push_back(mk(0,0,32'h00,0, 1,32'h08,32'h102,32'h0C,0,0,2));
        tbl.push_back(mk(0,0,32'h00,0, 1,32'h08,32'h102,32'h0C,0,0,2));
        tbl.push_back(mk(0,0,32'h00,0, 1,32'h08,32'h102,32'h0C,0,0,2));
        tbl.push_back(mk(0,0,32'h00,1, 1,32'h0C,32'h103,32'h10,0,0,3));
        tbl.push_back(mk(0,0,32'h00,0, 1,32'h0C,32'h103,32'h10,0,0,3));
        tbl.push_back(mk(0,1,32'h40,0, 0,32'h0C,32'h103,32'h40,0,0,3));
        tbl.push_back(mk(0,0,32'h00,0, 1,32'h40,32'h110,32'h44,0,0,3));
        tbl.push_back(mk(0,1,32'h7C,1, 0,32'h40,32'h110,32'h7C,0,0,4));
        tbl.push_back(mk(0,0,32'h00,1, 1,32'h7C,32'h11F,32'h80,0,0,4));
        tbl.push_back(mk(0,0,32'h00,0, 1,32'h7C,32'h11F,32'h80,1,1,4));
        tbl.push_back(mk(0,0,32'h00,1, 0,32'h7C,32'h11F,32'h80,1,1,5));
        tbl.push_back(mk(0,0,32'h00,1, 0,32'h7C,32'h11F,32'h80,1,1,5));
        tbl.push_back(mk(0,1,32'h00,1, 0,32'h7C,32'h11F,32'h00,0,0,5));
        tbl.push_back(mk(0,0,32'h00,1, 1,32'h00,32'h100,32'h04,0,0,5));
        tbl.push_back(mk(0,1,32'h42,0, 0,32'h00,32'h100,32'h42,1,1,5));
        tbl.push_back(mk(0,0,32'h00,1, 0,32'h00,32'h100,32'h42,1,1,5));
        tbl.push_back(mk(0,1,32'h08,1, 0,32'h00,32'h100,32'h08,0,0,5));
        tbl.push_back(mk(0,0,32'h00,1, 1,32'h08,32'h102,32'h0C,0,0,5));
        tbl.push_back(mk(0,0,32'h00,1, 1,32'h0C,32'h103,32'h10,0,0,6));
        tbl.push_back(mk(1,0,32'h00,1, 0,32'h00,32'h000,32'h00,0,0,0));
        tbl.push_back(mk(0,1,32'h80,1, 0,32'h00,32'h000,32'h80,1,1,0));
        tbl.push_back(mk(1,1,32'h40,1, 0,32'h00,32'h000,32'h00,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
            @(posedge clk);
            #1;
            chk($sformatf("row%0d valid", i), 32'(bus.instr_valid), 32'(tbl[i].e_valid));
            chk($sformatf("row%0d instr_pc", i), bus.instr_pc, tbl[i].e_ipc);
            chk($sformatf("row%0d instr", i), bus.instr, tbl[i].e_instr);
            chk($sformatf("row%0d imem_addr", i), bus.imem_addr, tbl[i].e_addr);
            chk($sformatf("row%0d halted", i), 32'(halted), 32'(tbl[i].e_halt));
            chk($sformatf("row%0d fault", i), 32'(fault), 32'(tbl[i].e_fault));
            chk($sformatf("row%0d fetch_count", i), fetch_count, tbl[i].e_cnt);
        end

        for (int k = 0; k < 32; k++) mem[k] = $urandom;

        for (int c = 0; c < 3000; c++) begin
            logic        r, rv, rdy;
            logic [31:0] rpc;
            r   = (c == 0) || ($urandom_range(0, 99) == 0);
            rv  = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            rpc = 32'($urandom_range(0, 40)) * 4;
            if ($urandom_range(0, 7) == 0) rpc = rpc | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) rpc = 32'h70;
            drive(r, rv, rpc, rdy);
            model_step(r, rv, rpc, rdy);
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d valid", c), 32'(bus.instr_valid), 32'(m_valid));
            chk($sformatf("rnd%0d imem_addr", c), bus.imem_addr, m_pc);
            chk($sformatf("rnd%0d halted", c), 32'(halted), 32'(m_halt));
            chk($sformatf("rnd%0d fault", c), 32'(fault), 32'(m_fault));
            chk($sformatf("rnd%0d fetch_count", c), fetch_count, m_cnt);
            if (m_valid) begin
                chk($sformatf("rnd%0d instr_pc", c), bus.instr_pc, m_ipc);
                chk($sformatf("rnd%0d instr", c), bus.instr, m_instr);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
